// File: rtl/alu_cmd_ctrl.sv
// Command front-end for the 8-bit ALU: registers operands, waits the settle
// time, captures the 9-bit result and counts completed (and carry) results.
module alu_cmd_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [8:0]       alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [8:0]       res_data,
  output logic [3:0]       res_sel,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] carry_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       accept;
  logic       complete;
  logic       settled;

  assign accept   = cmd_valid & cmd_ready;
  assign complete = res_valid & res_ready;
  assign settled  = (state == EXEC) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cmd_valid) state_nx = EXEC;
      EXEC: if (cnt == 4'd0) state_nx = DONE;
      DONE: begin
        if (res_ready) state_nx = cmd_valid ? EXEC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      EXEC: cmd_ready = 1'b0;
      DONE: begin
        res_valid = 1'b1;
        cmd_ready = res_ready;
      end
      default: busy = 1'b0;
    endcase
  end

  // ALU inputs move only on acceptance so they stay stable through EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      cnt      <= '0;
      res_data <= '0;
      res_sel  <= '0;
    end else begin
      if (accept) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_sel;
        cnt     <= LOAD;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (settled) begin
        res_data <= alu_result;
        res_sel  <= alu_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count    <= '0;
      carry_count <= '0;
    end else if (complete) begin
      if (op_count != CMAX)
        op_count <= op_count + 1'b1;
      if (res_data[8] && carry_count != CMAX)
        carry_count <= carry_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: vector table plus scoreboard, two DUT
// instances (settle 1 / 16-bit counters and settle 3 / 2-bit counters).
module tb_alu_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst1, rst2;
  logic       cmd_valid, res_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_sel;
  logic       sat;

  logic        c1_ready, v1, busy1;
  logic [7:0]  a1, b1;
  logic [3:0]  s1, rs1;
  logic [8:0]  r1, dat1;
  logic [15:0] op1, ca1;

  logic        c2_ready, v2, busy2;
  logic [7:0]  a2, b2;
  logic [3:0]  s2, rs2;
  logic [8:0]  r2, dat2;
  logic [1:0]  op2, ca2;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [12:0] sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] alu_f(
    input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    case (s)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign r1 = alu_f(a1, b1, s1);
  assign r2 = alu_f(a2, b2, s2);

  alu_cmd_ctrl #(.SETTLE_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst1), .cmd_valid(cmd_valid), .cmd_ready(c1_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(a1), .alu_b(b1), .alu_sel(s1), .alu_result(r1),
    .res_valid(v1), .res_ready(res_ready), .res_data(dat1),
    .res_sel(rs1), .busy(busy1), .op_count(op1), .carry_count(ca1));

  alu_cmd_ctrl #(.SETTLE_CYCLES(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst2), .cmd_valid(cmd_valid), .cmd_ready(c2_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(a2), .alu_b(b2), .alu_sel(s2), .alu_result(r2),
    .res_valid(v2), .res_ready(res_ready), .res_data(dat2),
    .res_sel(rs2), .busy(busy2), .op_count(op2), .carry_count(ca2));

  logic       cur_rst, cur_ready, cur_valid;
  logic [8:0] cur_data;
  logic [3:0] cur_sel;
  assign cur_rst   = sat ? rst2 : rst1;
  assign cur_ready = sat ? c2_ready : c1_ready;
  assign cur_valid = sat ? v2 : v1;
  assign cur_data  = sat ? dat2 : dat1;
  assign cur_sel   = sat ? rs2 : rs1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cur_rst) begin
      sbq.delete();
    end else if (cur_valid && res_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", {23'd0, cur_data}, 32'h0);
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_result: got data %0h with empty scoreboard",
                 cur_data);
      end else begin
        logic [12:0] e;
        e = sbq.pop_front();
        chk("sb_res_data", {23'd0, cur_data}, {23'd0, e[8:0]});
        chk("sb_res_sel", {28'd0, cur_sel}, {28'd0, e[12:9]});
      end
    end
  end

  // returns the cycle number of the accepting edge
  task automatic send(input vec_t v, output int acc);
    bit ok = 0;
    cmd_a = v.a; cmd_b = v.b; cmd_sel = v.sel; cmd_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cur_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_fail++;
      $display("FAIL send_timeout: cmd_ready never high");
    end else begin
      sbq.push_back({v.sel, v.exp});
    end
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    bit ok = 0;
    at = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cur_valid) begin ok = 1; at = cyc; break; end
    end
    if (!ok) begin
      n_vec++; n_fail++;
      $display("FAIL valid_timeout: res_valid never high");
    end
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !cur_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding", sbq.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e1, e2, m;
    bit seen;
    tbl[0] = '{8'hFF, 8'h00, 4'd0, 9'h0FF};
    tbl[1] = '{8'hF0, 8'h0F, 4'd0, 9'h0FF};
    tbl[2] = '{8'hFF, 8'hFF, 4'd0, 9'h1FE};
    tbl[3] = '{8'h10, 8'h20, 4'd1, 9'h1F0};
    tbl[4] = '{8'hA5, 8'h3C, 4'd2, 9'h024};
    tbl[5] = '{8'hA5, 8'h3C, 4'd3, 9'h0BD};
    tbl[6] = '{8'hA5, 8'h3C, 4'd4, 9'h099};
    tbl[7] = '{8'h80, 8'h80, 4'd0, 9'h100};

    sat = 1'b0; rst1 = 1'b1; rst2 = 1'b1;
    cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0;

    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
    chk("rst_cmd_ready", c1_ready, 1);
    chk("rst_res_valid", v1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_alu_a", a1, 0);
    chk("rst_alu_b", b1, 0);
    chk("rst_alu_sel", s1, 0);
    chk("rst_op_count", op1, 0);
    chk("rst_carry_count", ca1, 0);

    res_ready = 1'b1;
    send(tbl[0], e1);
    chk("exec_res_valid", v1, 0);
    chk("exec_busy", busy1, 1);
    chk("exec_cmd_ready", c1_ready, 0);
    chk("exec_alu_a", a1, 8'hFF);
    chk("exec_alu_b", b1, 8'h00);
    @(posedge clk); #1;
    chk("lat1_res_valid", v1, 1);
    chk("lat1_res_data", dat1, 9'h0FF);
    chk("lat1_res_sel", rs1, 0);
    @(posedge clk); #1;
    chk("single_op_count", op1, 1);
    chk("single_carry_count", ca1, 0);
    chk("single_back_idle", busy1, 0);

    send(tbl[1], e1);
    send(tbl[2], e2);
    chk("b2b_no_bubble", e2 - e1, 2);
    wait_drain();
    chk("b2b_op_count", op1, 3);
    chk("b2b_carry_count", ca1, 1);

    res_ready = 1'b0;
    send(tbl[2], e1);
    wait_valid(m);
    @(posedge clk); #1;
    cmd_a = tbl[3].a; cmd_b = tbl[3].b; cmd_sel = tbl[3].sel;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res_valid", v1, 1);
      chk("bp_res_data", dat1, 9'h1FE);
      chk("bp_cmd_ready", c1_ready, 0);
      chk("bp_alu_a_held", a1, 8'hFF);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", c1_ready, 1);
    sbq.push_back({tbl[3].sel, tbl[3].exp});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_accept_alu_a", a1, 8'h10);
    chk("bp_accept_alu_sel", s1, 1);
    chk("bp_accept_busy", busy1, 1);
    chk("bp_accept_valid", v1, 0);
    wait_drain();

    for (int i = 4; i < 8; i++) send(tbl[i], e1);
    wait_drain();
    chk("tbl_op_count", op1, 9);
    chk("tbl_carry_count", ca1, 4);

    send(tbl[0], e1);
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    chk("midrst_busy", busy1, 0);
    chk("midrst_res_valid", v1, 0);
    chk("midrst_cmd_ready", c1_ready, 1);
    chk("midrst_op_count", op1, 0);
    chk("midrst_alu_a", a1, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (v1) seen = 1;
    end
    chk("midrst_no_result", seen, 0);
    @(posedge clk); #1;

    rst1 = 1'b1; sat = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    chk("sat_rst_op_count", op2, 0);
    send(tbl[2], e1);
    wait_valid(m);
    chk("settle3_latency", m - e1, 3);
    for (int i = 0; i < 4; i++) send(tbl[2], e2);
    wait_drain();
    chk("sat_op_count", op2, 3);
    chk("sat_carry_count", ca2, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
